sc_death_event_ctrl: RTL

//  Upstream of the lives counter. Filters the frog/obstacle collision level and runs the death sequence.

---
 rtl/sc_game_pkg.sv | 26 ++
 rtl/sc_cycle_timer.sv | 29 ++
 rtl/sc_death_event_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sc_game_pkg.sv
// Shared definitions for the frog game control blocks: state encoding,
// default timing constants at 50 MHz and a duration range helper.
package sc_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_HIT     = 3'd2,
        ST_DYING   = 3'd3,
        ST_RESPAWN = 3'd4,
        ST_GRACE   = 3'd5,
        ST_OVER    = 3'd6
    } state_t;

    localparam int DEF_TIMER_WIDTH  = 26;
    localparam int DEF_COLL_FILTER  = 4;
    localparam int DEF_DEATH_CYCLES = 25_000_000;  // 0.5 s
    localparam int DEF_GRACE_CYCLES = 50_000_000;  // 1.0 s
    localparam int DEF_BLINK_HALF   = 6_250_000;   // 125 ms

    // A duration is usable when (cycles-1) can be loaded into a width-bit timer.
    function automatic logic duration_fits(input int cycles, input int width);
        return (cycles >= 1) && (longint'(cycles) < (longint'(1) << width));
    endfunction

endpackage

// File: rtl/sc_cycle_timer.sv
// Loadable down-counter. Load has priority; the count stops at zero and
// expired is high whenever the count reads zero.
module sc_cycle_timer #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Reload on request, otherwise count down towards zero and hold there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sc_death_event_ctrl.sv
// Death sequence controller sitting in front of the lives counter.
// Filters the collision level, emits one active-low lifelost pulse per hit,
// freezes/blinks the frog while dying, respawns it, then grants a grace window.
// Handshake note: there is no valid/ready pair here; every output is a Moore
// decode of registered state, and the two *_OutLow pulses are single-cycle
// strobes that the downstream counter/position register consume unconditionally.
module sc_death_event_ctrl
    import sc_game_pkg::*;
#(
    parameter int TIMER_WIDTH  = DEF_TIMER_WIDTH,
    parameter int COLL_FILTER  = DEF_COLL_FILTER,
    parameter int DEATH_CYCLES = DEF_DEATH_CYCLES,
    parameter int GRACE_CYCLES = DEF_GRACE_CYCLES,
    parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
    input  logic       SC_DEATH_CTRL_CLOCK_50,
    input  logic       SC_DEATH_CTRL_RESET_InLow,
    input  logic       SC_DEATH_CTRL_enable_InHigh,
    input  logic       SC_DEATH_CTRL_collision_InHigh,
    input  logic       SC_DEATH_CTRL_goal_InHigh,
    input  logic       SC_DEATH_CTRL_gameover_InHigh,
    output logic       SC_DEATH_CTRL_lifelost_OutLow,
    output logic       SC_DEATH_CTRL_respawn_OutLow,
    output logic       SC_DEATH_CTRL_freeze_OutHigh,
    output logic       SC_DEATH_CTRL_blink_OutHigh,
    output logic [2:0] SC_DEATH_CTRL_state_dbg
);

    // Parameter sanity: refuse to elaborate with durations the timer cannot hold.
    if (!duration_fits(DEATH_CYCLES, TIMER_WIDTH)) begin : g_bad_death
        $error("DEATH_CYCLES must be >=1 and fit in TIMER_WIDTH bits");
    end
    if (!duration_fits(GRACE_CYCLES, TIMER_WIDTH)) begin : g_bad_grace
        $error("GRACE_CYCLES must be >=1 and fit in TIMER_WIDTH bits");
    end
    if (!duration_fits(BLINK_HALF, TIMER_WIDTH)) begin : g_bad_blink
        $error("BLINK_HALF must be >=1 and fit in TIMER_WIDTH bits");
    end
    if (COLL_FILTER < 1) begin : g_bad_filter
        $error("COLL_FILTER must be >=1");
    end

    localparam int FW = $clog2(COLL_FILTER + 1);
    localparam logic [FW-1:0]          FILT_LAST  = FW'(COLL_FILTER - 1);
    localparam logic [TIMER_WIDTH-1:0] DEATH_LOAD = TIMER_WIDTH'(DEATH_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] GRACE_LOAD = TIMER_WIDTH'(GRACE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] BLINK_LOAD = TIMER_WIDTH'(BLINK_HALF - 1);

    logic clk;
    logic rst_n;
    logic enable;
    logic collision;
    logic goal;
    logic gameover;

    assign clk       = SC_DEATH_CTRL_CLOCK_50;
    assign rst_n     = SC_DEATH_CTRL_RESET_InLow;
    assign enable    = SC_DEATH_CTRL_enable_InHigh;
    assign collision = SC_DEATH_CTRL_collision_InHigh;
    assign goal      = SC_DEATH_CTRL_goal_InHigh;
    assign gameover  = SC_DEATH_CTRL_gameover_InHigh;

    state_t                  state;
    state_t                  state_next;
    logic [FW-1:0]           filt_cnt;
    logic                    filt_done;
    logic                    blink_q;
    logic                    dur_load;
    logic [TIMER_WIDTH-1:0]  dur_value;
    logic                    dur_exp;
    logic                    blink_load;
    logic                    blink_exp;

    // The Nth consecutive collision-high edge in PLAY confirms a hit.
    assign filt_done = (state == ST_PLAY) && collision && (filt_cnt == FILT_LAST);

    // Next-state decode; enable low overrides every other condition.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_next = ST_PLAY;
                ST_PLAY: begin
                    if (gameover)       state_next = ST_OVER;
                    else if (filt_done) state_next = ST_HIT;
                    else if (goal)      state_next = ST_RESPAWN;
                end
                ST_HIT:     state_next = ST_DYING;
                ST_DYING: begin
                    if (dur_exp) state_next = gameover ? ST_OVER : ST_RESPAWN;
                end
                ST_RESPAWN: state_next = ST_GRACE;
                ST_GRACE: begin
                    if (gameover)     state_next = ST_OVER;
                    else if (dur_exp) state_next = ST_PLAY;
                end
                ST_OVER:    state_next = ST_OVER;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Timer loads: the duration timer on DYING/GRACE entry, the blink timer on
    // DYING entry and again at each half-period boundary while dying.
    always_comb begin
        dur_load   = (state_next != state) &&
                     ((state_next == ST_DYING) || (state_next == ST_GRACE));
        dur_value  = (state_next == ST_DYING) ? DEATH_LOAD : GRACE_LOAD;
        blink_load = (state_next == ST_DYING) && ((state != ST_DYING) || blink_exp);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Collision streak counter: only runs while staying in PLAY with collision high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
        end else if ((state_next != state) || (state != ST_PLAY) || !collision) begin
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // Blink phase: starts visible-blanked (1) on DYING entry, toggles each half period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
        end else if (state_next != ST_DYING) begin
            blink_q <= 1'b0;
        end else if (state != ST_DYING) begin
            blink_q <= 1'b1;
        end else if (blink_exp) begin
            blink_q <= ~blink_q;
        end
    end

    sc_cycle_timer #(.WIDTH(TIMER_WIDTH)) u_dur_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (dur_load),
        .load_value (dur_value),
        .enable     (1'b1),
        .expired    (dur_exp)
    );

    sc_cycle_timer #(.WIDTH(TIMER_WIDTH)) u_blink_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (blink_load),
        .load_value (BLINK_LOAD),
        .enable     (1'b1),
        .expired    (blink_exp)
    );

    assign SC_DEATH_CTRL_lifelost_OutLow = (state != ST_HIT);
    assign SC_DEATH_CTRL_respawn_OutLow  = (state != ST_RESPAWN);
    assign SC_DEATH_CTRL_freeze_OutHigh  = (state == ST_HIT) || (state == ST_DYING) ||
                                           (state == ST_RESPAWN) || (state == ST_OVER);
    assign SC_DEATH_CTRL_blink_OutHigh   = blink_q;
    assign SC_DEATH_CTRL_state_dbg       = state;

endmodule
